mpx_pilot_seq: RTL and testbench
================================

Name: mpx_pilot_seq

Overview:
Sequencer for the stereo MPX pilot path. On start it streams a stored byte table into the DDS configuration port (cfg/cfg_ce). It then soft-starts the pilot by ramping pilot_gain from 0 to a target, which avoids spectral splatter at pilot turn-on. On stop it ramps the gain back to 0. It sits between the MPX register bank and the DDS/gain stage, replacing direct register drive of dds_cfg, dds_cfg_ce and pilot_gain.

Parameters:
CFG_DEPTH, 16, number of entries in the 8-bit DDS config table (power of 2)
GAIN_WIDTH, 16, width of the pilot gain word (unsigned, radix set by the downstream gain stage)
DIV_WIDTH, 16, width of the ramp tick divider

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: begin load and ramp-up
stop  in  1  single-cycle pulse: begin ramp-down / abort
tbl_wr_en  in  1  table write strobe
tbl_wr_addr  in  $clog2(CFG_DEPTH)  table write address
tbl_wr_data  in  8  table write data
tbl_len  in  $clog2(CFG_DEPTH)+1  number of bytes to stream (0 = skip load)
target_gain  in  GAIN_WIDTH  final pilot gain
ramp_step  in  GAIN_WIDTH  gain change per tick
ramp_div  in  DIV_WIDTH  tick period minus 1, in clk cycles
dds_cfg  out  8  config byte to DDS
dds_cfg_ce  out  1  config byte valid
pilot_gain  out  GAIN_WIDTH  gain to pilot scaler
state  out  3  IDLE=0, LOAD=1, RAMP_UP=2, RUN=3, RAMP_DOWN=4
busy  out  1  state != IDLE
done  out  1  1-cycle pulse on entering RUN or returning to IDLE from RAMP_DOWN

Behaviour:
- Reset: state=IDLE; dds_cfg=0, dds_cfg_ce=0, pilot_gain=0, done=0; table entries=0; idx=0; tick counter=0. A reset asserted in any state takes effect on the next edge, and all outputs return to these values.
- All outputs are registered.
- Table writes are accepted only in IDLE and are ignored in any other state.
- Stop has priority over start when both are asserted in the same cycle.
- IDLE: pilot_gain held at 0.
  - start with tbl_len>0 → LOAD, idx=0.
  - start with tbl_len=0 → RAMP_UP.
  - stop → no effect.
- LOAD: one byte per cycle.
  - Cycle k after the start edge: dds_cfg=tbl[k], dds_cfg_ce=1.
  - After byte tbl_len-1 is issued → RAMP_UP; dds_cfg_ce=0 on the following cycle.
  - tbl_len>CFG_DEPTH is clamped to CFG_DEPTH.
  - stop → IDLE immediately; remaining bytes are not sent; dds_cfg_ce=0 next cycle.
  - start → ignored.
- Tick: the counter clears on entry to RAMP_UP or RAMP_DOWN. A tick fires when count==ramp_div, and the counter then returns to 0. The first tick therefore lands ramp_div+1 cycles after entry; ramp_div=0 gives a tick every cycle.
- RAMP_UP: on each tick, pilot_gain = min(gain+ramp_step, target_gain).
  - The sum is computed at GAIN_WIDTH+1 bits, so there is no wrap.
  - ramp_step=0 is treated as a jump to target_gain on the first tick.
  - gain==target_gain → RUN with a done pulse. This includes target_gain=0, which leaves RAMP_UP on the first tick.
  - stop → RAMP_DOWN from the current gain.
  - start → ignored.
- RUN: pilot_gain follows target_gain with 1-cycle latency.
  - stop → RAMP_DOWN.
  - start → ignored.
- RAMP_DOWN: on each tick, pilot_gain = (gain>ramp_step) ? gain-ramp_step : 0, with ramp_step=0 treated as a jump to 0.
  - gain==0 → IDLE with a done pulse.
  - start → RAMP_UP from the current gain; no table reload.
- ramp_step, ramp_div and target_gain are sampled live each cycle and are not latched at start.

Test Plan:
- Load + ramp. Setup: tbl[0..3]=11,22,33,44; tbl_len=4; target=0x0100; step=0x40; div=0. Pulse start. → dds_cfg_ce high for 4 consecutive cycles carrying 11,22,33,44. Then, on successive cycles (the first 1 cycle after ce drops), pilot_gain=0x40, 0x80, 0xC0, 0x100; state=3 with done pulsed once.
- Saturation/divider. Setup: tbl_len=0; target=0x0100; step=0x60; div=3. → no dds_cfg_ce. pilot_gain=0x60, 0xC0, 0x100 at 4-cycle intervals, then RUN.
- Ramp-down from RUN. Setup: gain=0x100; step=0x60; div=0; pulse stop. → gain 0xA0, 0x40, 0x00, then IDLE; done pulses; busy falls.
- Aborts:
  - stop on the 2nd LOAD cycle → exactly 2 ce bytes, then IDLE with gain 0.
  - stop mid RAMP_UP at gain 0x80 → ramp-down from 0x80.
  - start during RAMP_DOWN → ramp-up resumes with no ce.
- Edge cases:
  - step=0 → gain jumps to target on the first tick.
  - start+stop in the same cycle in IDLE → stays IDLE.
  - tbl write during LOAD → table unchanged on a subsequent run.
- Reset mid-RAMP_UP → next cycle state=0, pilot_gain=0, dds_cfg_ce=0, table reads back 0.

Source files
------------

// File: rtl/mpx_pilot_seq.sv
// Stereo MPX pilot sequencer: streams a stored DDS config table on start, then
// soft-starts / soft-stops the pilot gain with a divided-tick linear ramp.
module mpx_pilot_seq #(
  parameter int CFG_DEPTH  = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_tbl_wr_en,
  input  logic [$clog2(CFG_DEPTH)-1:0] i_tbl_wr_addr,
  input  logic [7:0]                   i_tbl_wr_data,
  input  logic [$clog2(CFG_DEPTH):0]   i_tbl_len,
  input  logic [GAIN_WIDTH-1:0]        i_target_gain,
  input  logic [GAIN_WIDTH-1:0]        i_ramp_step,
  input  logic [DIV_WIDTH-1:0]         i_ramp_div,
  output logic [7:0]                   o_dds_cfg,
  output logic                         o_dds_cfg_ce,
  output logic [GAIN_WIDTH-1:0]        o_pilot_gain,
  output logic [2:0]                   o_state,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int AW = $clog2(CFG_DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(CFG_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_RUN       = 3'd3,
    S_RAMP_DOWN = 3'd4
  } state_t;

  logic [7:0]            r_tbl [CFG_DEPTH];
  state_t                r_state, w_state_nxt;
  logic [AW:0]           r_idx, w_idx_nxt;
  logic [DIV_WIDTH-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [GAIN_WIDTH-1:0] r_gain, w_gain_nxt, w_gain_up, w_gain_dn;
  logic [GAIN_WIDTH:0]   w_sum;
  logic [7:0]            r_cfg, w_cfg_nxt;
  logic                  r_cfg_ce, w_cfg_ce_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_busy;
  logic [AW:0]           w_len;
  logic                  w_tick;
  logic                  w_start_only;

  assign w_len        = (i_tbl_len > L_DEPTH) ? L_DEPTH : i_tbl_len;
  assign w_tick       = (r_cnt == i_ramp_div);
  assign w_cnt_inc    = w_tick ? '0 : r_cnt + DIV_WIDTH'(1);
  assign w_start_only = i_start & ~i_stop;

  // One bit of headroom so gain+step can never wrap before the clamp.
  assign w_sum     = {1'b0, r_gain} + {1'b0, i_ramp_step};
  assign w_gain_up = ((i_ramp_step == '0) || (w_sum >= {1'b0, i_target_gain}))
                     ? i_target_gain : w_sum[GAIN_WIDTH-1:0];
  assign w_gain_dn = ((i_ramp_step == '0) || (r_gain <= i_ramp_step))
                     ? '0 : r_gain - i_ramp_step;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_gain_nxt   = r_gain;
    w_cfg_nxt    = r_cfg;
    w_cfg_ce_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gain_nxt = '0;
        if (w_start_only) begin
          if (w_len != '0) begin
            // First byte goes out on the start edge itself.
            w_state_nxt  = S_LOAD;
            w_cfg_nxt    = r_tbl[0];
            w_cfg_ce_nxt = 1'b1;
            w_idx_nxt    = (AW+1)'(1);
          end else begin
            w_state_nxt = S_RAMP_UP;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_idx_nxt = '0;
        end
      end
      S_LOAD: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else if (r_idx >= w_len) begin
          w_state_nxt = S_RAMP_UP;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cfg_nxt    = r_tbl[r_idx[AW-1:0]];
          w_cfg_ce_nxt = 1'b1;
          w_idx_nxt    = r_idx + (AW+1)'(1);
        end
      end
      S_RAMP_UP: begin
        if (i_stop) begin
          w_state_nxt = S_RAMP_DOWN;
          w_cnt_nxt   = '0;
        end else if (w_tick) begin
          w_gain_nxt = w_gain_up;
          w_cnt_nxt  = '0;
          if (w_gain_up == i_target_gain) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RAMP_UP;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RUN: begin
        w_gain_nxt = i_target_gain;
        if (i_stop) begin
          w_state_nxt = S_RAMP_DOWN;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RAMP_DOWN: begin
        if (w_start_only) begin
          w_state_nxt = S_RAMP_UP;
          w_cnt_nxt   = '0;
        end else if (w_tick) begin
          w_gain_nxt = w_gain_dn;
          w_cnt_nxt  = '0;
          if (w_gain_dn == '0) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RAMP_DOWN;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gain_nxt  = '0;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_gain   <= '0;
      r_cfg    <= 8'd0;
      r_cfg_ce <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gain   <= w_gain_nxt;
      r_cfg    <= w_cfg_nxt;
      r_cfg_ce <= w_cfg_ce_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  // Table is only writable while idle so a running load sees a stable image.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CFG_DEPTH; i++) begin
        r_tbl[i] <= 8'd0;
      end
    end else if (i_tbl_wr_en && (r_state == S_IDLE)) begin
      r_tbl[i_tbl_wr_addr] <= i_tbl_wr_data;
    end
  end

  assign o_dds_cfg    = r_cfg;
  assign o_dds_cfg_ce = r_cfg_ce;
  assign o_pilot_gain = r_gain;
  assign o_state      = r_state;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_mpx_pilot_seq.sv
// Directed self-checking bench for mpx_pilot_seq.
module tb_mpx_pilot_seq;
  localparam int CFG_DEPTH = 16;
  localparam int GW = 16;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start, i_stop, i_tbl_wr_en;
  logic [AW-1:0] i_tbl_wr_addr;
  logic [7:0]    i_tbl_wr_data;
  logic [AW:0]   i_tbl_len;
  logic [GW-1:0] i_target_gain, i_ramp_step;
  logic [DW-1:0] i_ramp_div;
  logic [7:0]    o_dds_cfg;
  logic          o_dds_cfg_ce;
  logic [GW-1:0] o_pilot_gain;
  logic [2:0]    o_state;
  logic          o_busy, o_done;

  int n_checks = 0;
  int n_errors = 0;
  int ce_cnt;
  logic [7:0]  tbl_bytes [4] = '{8'd11, 8'd22, 8'd33, 8'd44};
  logic [15:0] sat_exp [4]   = '{16'h0000, 16'h0060, 16'h00C0, 16'h0100};
  logic [15:0] dn_exp [3]    = '{16'h00A0, 16'h0040, 16'h0000};

  always #5 clk = ~clk;

  mpx_pilot_seq #(.CFG_DEPTH(CFG_DEPTH), .GAIN_WIDTH(GW), .DIV_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop),
    .i_tbl_wr_en(i_tbl_wr_en), .i_tbl_wr_addr(i_tbl_wr_addr), .i_tbl_wr_data(i_tbl_wr_data),
    .i_tbl_len(i_tbl_len), .i_target_gain(i_target_gain), .i_ramp_step(i_ramp_step),
    .i_ramp_div(i_ramp_div), .o_dds_cfg(o_dds_cfg), .o_dds_cfg_ce(o_dds_cfg_ce),
    .o_pilot_gain(o_pilot_gain), .o_state(o_state), .o_busy(o_busy), .o_done(o_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic pulse_stop();
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
  endtask

  task automatic write_tbl(input logic [AW-1:0] addr, input logic [7:0] data);
    i_tbl_wr_en   = 1'b1;
    i_tbl_wr_addr = addr;
    i_tbl_wr_data = data;
    @(negedge clk);
    i_tbl_wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (o_state !== 3'd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_reached", o_state, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_tbl_wr_en = 1'b0;
    i_tbl_wr_addr = '0; i_tbl_wr_data = 8'd0; i_tbl_len = '0;
    i_target_gain = '0; i_ramp_step = '0; i_ramp_div = '0;
    repeat (3) @(negedge clk);
    check_val("rst_state", o_state, 3'd0);
    check_val("rst_gain", o_pilot_gain, 16'h0);
    check_val("rst_ce", o_dds_cfg_ce, 1'b0);
    check_val("rst_cfg", o_dds_cfg, 8'd0);
    check_val("rst_done", o_done, 1'b0);
    check_val("rst_busy", o_busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Load + ramp-up
    for (int k = 0; k < 4; k++) write_tbl(AW'(k), tbl_bytes[k]);
    i_tbl_len = 5'd4; i_target_gain = 16'h0100; i_ramp_step = 16'h0040; i_ramp_div = 16'd0;
    pulse_start();
    check_val("load_state", o_state, 3'd1);
    check_val("load_busy", o_busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check_val("load_ce", o_dds_cfg_ce, 1'b1);
      check_val("load_byte", o_dds_cfg, tbl_bytes[k]);
      @(negedge clk);
    end
    check_val("load_ce_drop", o_dds_cfg_ce, 1'b0);
    check_val("rampup_state", o_state, 3'd2);
    check_val("rampup_gain0", o_pilot_gain, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_val("rampup_gain", o_pilot_gain, 16'(k * 16'h40));
      check_val("rampup_st", o_state, (k == 4) ? 3'd3 : 3'd2);
      check_val("rampup_done", o_done, (k == 4) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check_val("run_done_once", o_done, 1'b0);
    check_val("run_gain", o_pilot_gain, 16'h0100);

    // Ramp-down from RUN
    i_ramp_step = 16'h0060;
    pulse_stop();
    check_val("rd_state", o_state, 3'd4);
    check_val("rd_gain0", o_pilot_gain, 16'h0100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("rd_gain", o_pilot_gain, dn_exp[k]);
      check_val("rd_st", o_state, (k == 2) ? 3'd0 : 3'd4);
      check_val("rd_done", o_done, (k == 2) ? 1'b1 : 1'b0);
      check_val("rd_busy", o_busy, (k == 2) ? 1'b0 : 1'b1);
    end

    // Saturation with divider, no load
    i_tbl_len = 5'd0; i_target_gain = 16'h0100; i_ramp_step = 16'h0060; i_ramp_div = 16'd3;
    ce_cnt = 0;
    pulse_start();
    check_val("sat_state", o_state, 3'd2);
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      ce_cnt += int'(o_dds_cfg_ce);
      check_val("sat_gain", o_pilot_gain, sat_exp[t / 4]);
    end
    check_val("sat_run", o_state, 3'd3);
    check_val("sat_done", o_done, 1'b1);
    check_val("sat_no_ce", ce_cnt, 0);
    i_ramp_div = 16'd0; i_ramp_step = 16'h0000;
    pulse_stop();
    wait_idle(20);

    // Stop on the 2nd LOAD cycle
    i_tbl_len = 5'd4; i_ramp_step = 16'h0040;
    pulse_start();
    check_val("ab_byte0", o_dds_cfg, 8'd11);
    @(negedge clk);
    check_val("ab_ce1", o_dds_cfg_ce, 1'b1);
    check_val("ab_byte1", o_dds_cfg, 8'd22);
    pulse_stop();
    check_val("ab_idle", o_state, 3'd0);
    check_val("ab_ce_off", o_dds_cfg_ce, 1'b0);
    check_val("ab_gain", o_pilot_gain, 16'h0);
    @(negedge clk);
    check_val("ab_no_more", o_dds_cfg_ce, 1'b0);

    // Stop mid RAMP_UP at 0x80
    i_tbl_len = 5'd0;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    check_val("mu_gain80", o_pilot_gain, 16'h0080);
    pulse_stop();
    check_val("mu_rd", o_state, 3'd4);
    check_val("mu_hold", o_pilot_gain, 16'h0080);
    @(negedge clk);
    check_val("mu_g40", o_pilot_gain, 16'h0040);
    @(negedge clk);
    check_val("mu_g0", o_pilot_gain, 16'h0);
    check_val("mu_idle", o_state, 3'd0);
    check_val("mu_done", o_done, 1'b1);

    // step=0 jumps to target; then start during RAMP_DOWN
    i_ramp_step = 16'h0000;
    pulse_start();
    @(negedge clk);
    check_val("jmp_gain", o_pilot_gain, 16'h0100);
    check_val("jmp_run", o_state, 3'd3);
    i_ramp_step = 16'h0040;
    pulse_stop();
    @(negedge clk);
    check_val("rs_gain", o_pilot_gain, 16'h00C0);
    pulse_start();
    check_val("rs_state", o_state, 3'd2);
    check_val("rs_hold", o_pilot_gain, 16'h00C0);
    check_val("rs_no_ce", o_dds_cfg_ce, 1'b0);
    @(negedge clk);
    check_val("rs_gain_up", o_pilot_gain, 16'h0100);
    check_val("rs_run", o_state, 3'd3);
    i_ramp_step = 16'h0000;
    pulse_stop();
    wait_idle(10);

    // start and stop together in IDLE
    i_start = 1'b1; i_stop = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_stop = 1'b0;
    check_val("ss_idle", o_state, 3'd0);
    check_val("ss_busy", o_busy, 1'b0);
    @(negedge clk);
    check_val("ss_idle2", o_state, 3'd0);

    // Table write during LOAD is ignored; target 0 leaves RAMP_UP on first tick
    i_tbl_len = 5'd2; i_target_gain = 16'h0000; i_ramp_step = 16'h0040;
    pulse_start();
    i_tbl_wr_en = 1'b1; i_tbl_wr_addr = 4'd0; i_tbl_wr_data = 8'hEE;
    @(negedge clk);
    i_tbl_wr_en = 1'b0;
    check_val("tw_byte1", o_dds_cfg, 8'd22);
    @(negedge clk);
    check_val("tw_rampup", o_state, 3'd2);
    @(negedge clk);
    check_val("tz_run", o_state, 3'd3);
    check_val("tz_done", o_done, 1'b1);
    pulse_stop();
    wait_idle(10);
    i_tbl_len = 5'd1;
    pulse_start();
    check_val("tw_unchanged", o_dds_cfg, 8'd11);
    pulse_stop();
    wait_idle(10);

    // Reset mid RAMP_UP
    i_tbl_len = 5'd0; i_target_gain = 16'h0100; i_ramp_step = 16'h0040; i_ramp_div = 16'd3;
    pulse_start();
    repeat (4) @(negedge clk);
    check_val("mr_gain", o_pilot_gain, 16'h0040);
    reset = 1'b1;
    @(negedge clk);
    check_val("mr_state", o_state, 3'd0);
    check_val("mr_gain0", o_pilot_gain, 16'h0);
    check_val("mr_ce", o_dds_cfg_ce, 1'b0);
    check_val("mr_busy", o_busy, 1'b0);
    reset = 1'b0;
    i_ramp_div = 16'd0; i_tbl_len = 5'd4;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      check_val("mr_tbl_ce", o_dds_cfg_ce, 1'b1);
      check_val("mr_tbl_zero", o_dds_cfg, 8'd0);
      @(negedge clk);
    end
    i_ramp_step = 16'h0000;
    pulse_stop();
    wait_idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
